// File: rtl/score_tick_scheduler_if.sv
// rtl/score_tick_scheduler_if.sv - signal bundle between game logic and the score tick scheduler
interface score_tick_scheduler_if;
  logic        start;
  logic        collide;
  logic        score_tick;
  logic        score_clr;
  logic        score_visible;
  logic        running;
  logic [2:0]  speed_level;
  logic [15:0] score_bcd;
  logic [15:0] hi_score_bcd;

  modport slave (
    input  start,
    input  collide,
    output score_tick,
    output score_clr,
    output score_visible,
    output running,
    output speed_level,
    output score_bcd,
    output hi_score_bcd
  );

  modport master (
    output start,
    output collide,
    input  score_tick,
    input  score_clr,
    input  score_visible,
    input  running,
    input  speed_level,
    input  score_bcd,
    input  hi_score_bcd
  );
endinterface

// File: rtl/score_tick_scheduler.sv
// rtl/score_tick_scheduler.sv - game FSM, speed-scaled score tick prescaler, score/high-score and milestone blink
module score_tick_scheduler #(
  parameter int unsigned TICK_DIV    = 5_000_000,
  parameter int unsigned DIV_STEP    = 500_000,
  parameter int unsigned MAX_LEVEL   = 7,
  parameter int unsigned BLINK_HALF  = 12_500_000,
  parameter int unsigned BLINK_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  score_tick_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_tick;
  logic        r_clr;
  logic        r_running;
  logic [2:0]  r_level;
  logic [15:0] r_score;
  logic [15:0] r_hi;
  logic [31:0] r_presc;

  logic        r_blink_active;
  logic        r_visible;
  logic [31:0] r_blink_cnt;
  logic [31:0] r_blink_pair;

  logic        w_enter_run;
  logic        w_enter_dead;
  logic [31:0] w_period;
  logic        w_presc_term;
  logic [15:0] w_score_inc;
  logic        w_milestone;
  logic [2:0]  w_level_next;

  // Per-digit BCD increment; a digit only rolls over when every lower digit rolled over.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (res[i*4 +: 4] == 4'd9) begin
          res[i*4 +: 4] = 4'd0;
        end else begin
          res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  assign w_period     = 32'(TICK_DIV) - 32'(r_level) * 32'(DIV_STEP);
  assign w_presc_term = (r_presc == w_period - 32'd1);
  assign w_score_inc  = bcd_inc(r_score);
  assign w_milestone  = (w_score_inc[7:0] == 8'h00);
  assign w_level_next = (r_level == 3'(MAX_LEVEL)) ? r_level : r_level + 3'd1;
  assign w_enter_run  = (r_state != S_RUN) && (w_next_state == S_RUN);
  assign w_enter_dead = (r_state == S_RUN) && (w_next_state == S_DEAD);

  // Game state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: collide wins in RUN, start is only honoured outside RUN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DEAD: begin
        if (bus.start) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (bus.collide) w_next_state = S_DEAD;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Registered outputs: prescaler, score/high score, speed level and milestone blink.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick         <= 1'b0;
      r_clr          <= 1'b0;
      r_running      <= 1'b0;
      r_level        <= 3'd0;
      r_score        <= 16'h0000;
      r_hi           <= 16'h0000;
      r_presc        <= 32'd0;
      r_blink_active <= 1'b0;
      r_visible      <= 1'b1;
      r_blink_cnt    <= 32'd0;
      r_blink_pair   <= 32'd0;
    end else begin
      r_tick    <= 1'b0;
      r_clr     <= 1'b0;
      r_running <= (w_next_state == S_RUN);
      if (w_enter_run) begin
        r_clr          <= 1'b1;
        r_score        <= 16'h0000;
        r_level        <= 3'd0;
        r_presc        <= 32'd0;
        r_blink_active <= 1'b0;
        r_visible      <= 1'b1;
        r_blink_cnt    <= 32'd0;
        r_blink_pair   <= 32'd0;
      end else if (w_enter_dead) begin
        // Packed BCD compares correctly as a plain unsigned number.
        if (r_score > r_hi) r_hi <= r_score;
        r_blink_active <= 1'b0;
        r_visible      <= 1'b1;
        r_blink_cnt    <= 32'd0;
        r_blink_pair   <= 32'd0;
      end else if (r_state == S_RUN) begin
        if (w_presc_term) begin
          r_presc <= 32'd0;
          r_tick  <= 1'b1;
          r_score <= w_score_inc;
          if (w_milestone) r_level <= w_level_next;
        end else begin
          r_presc <= r_presc + 32'd1;
        end

        if (w_presc_term && w_milestone) begin
          // A milestone always restarts the blink from its first off-phase.
          r_blink_active <= 1'b1;
          r_visible      <= 1'b0;
          r_blink_cnt    <= 32'd0;
          r_blink_pair   <= 32'd0;
        end else if (r_blink_active) begin
          if (r_blink_cnt == 32'(BLINK_HALF - 1)) begin
            r_blink_cnt <= 32'd0;
            if (!r_visible) begin
              r_visible <= 1'b1;
            end else if (r_blink_pair == 32'(BLINK_COUNT - 1)) begin
              r_blink_active <= 1'b0;
            end else begin
              r_blink_pair <= r_blink_pair + 32'd1;
              r_visible    <= 1'b0;
            end
          end else begin
            r_blink_cnt <= r_blink_cnt + 32'd1;
          end
        end
      end
    end
  end

  assign bus.score_tick    = r_tick;
  assign bus.score_clr     = r_clr;
  assign bus.score_visible = r_visible;
  assign bus.running       = r_running;
  assign bus.speed_level   = r_level;
  assign bus.score_bcd     = r_score;
  assign bus.hi_score_bcd  = r_hi;

endmodule
